// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter.
//   master: drives en, up_dn, load, load_val; observes count, tc, wrap
//   slave : the counter itself
interface updown_mod_counter_if #(
  parameter int unsigned WIDTH = 3
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up_dn, load, load_val,
    input  count, tc, wrap
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count, tc, wrap
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Prescaled up/down modulo counter with synchronous load, wrap/saturate
// mode, terminal-count flag and a one-cycle wrap pulse.
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : en/up_dn/load/load_val in, count/wrap (registered) and
//            tc (combinational from count and up_dn) out
module updown_mod_counter #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned MODULO   = 8,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SATURATE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  updown_mod_counter_if.slave  bus
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CW   = WIDTH + 1;
  localparam logic [CW-1:0]    MAX_EXT = CW'(MODULO - 1);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]  ps_q, ps_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             tick_c;
  logic [CW-1:0]    count_ext, load_ext, inc_ext, dec_ext;

  // Next-state: load beats tick beats hold; math is one bit wider than count
  always_comb begin
    count_ext = CW'(count_q);
    load_ext  = CW'(bus.load_val);
    inc_ext   = count_ext + CW'(1);
    dec_ext   = count_ext - CW'(1);
    tick_c    = bus.en && (ps_q == PS_LAST);
    ps_d      = ps_q;
    count_d   = count_q;
    wrap_d    = 1'b0;

    if (bus.load) begin
      count_d = (load_ext > MAX_EXT) ? WIDTH'(MAX_EXT) : bus.load_val;
      ps_d    = '0;
    end else if (tick_c) begin
      ps_d = '0;
      if (bus.up_dn) begin
        if (count_ext == MAX_EXT) begin
          if (SATURATE == 0) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = WIDTH'(inc_ext);
        end
      end else begin
        if (count_q == '0) begin
          if (SATURATE == 0) begin
            count_d = WIDTH'(MAX_EXT);
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = WIDTH'(dec_ext);
        end
      end
    end else if (bus.en) begin
      ps_d = ps_q + PS_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_q    <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  // Terminal count tracks up_dn without waiting for a clock edge
  assign bus.tc    = bus.up_dn ? (count_ext == MAX_EXT) : (count_q == '0);

endmodule
